// File: rtl/c157x_fser_port_if.sv
// Bus bundle for c157x_fser_port: host FIFO access, status/interrupt and the
// two-wire serial bus. clk and reset stay outside as plain ports.
interface c157x_fser_port_if #(
  parameter int DATA_W = 8
);
  logic              ce;
  logic              dir;
  logic [DATA_W-1:0] tx_data;
  logic              tx_wr;
  logic              tx_full;
  logic [DATA_W-1:0] rx_data;
  logic              rx_rd;
  logic              rx_empty;
  logic              sp_in;
  logic              cnt_in;
  logic              sp_out;
  logic              cnt_out;
  logic [3:0]        status;
  logic [3:0]        clr;
  logic              irq;

  modport slave (
    input  ce, dir, tx_data, tx_wr, rx_rd, sp_in, cnt_in, clr,
    output tx_full, rx_data, rx_empty, sp_out, cnt_out, status, irq
  );

  modport master (
    output ce, dir, tx_data, tx_wr, rx_rd, sp_in, cnt_in, clr,
    input  tx_full, rx_data, rx_empty, sp_out, cnt_out, status, irq
  );
endinterface

// File: rtl/c157x_fser_port.sv
// Half-duplex serial port: MSB-first clocked bus with TX/RX FIFOs,
// sticky status bits and a registered interrupt.
module c157x_fser_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push_i,
  input  logic [W-1:0] data_i,
  input  logic         pop_i,
  output logic [W-1:0] data_o,
  output logic         full_o,
  output logic         empty_o
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   cnt_q;
  logic          pop_s, push_s;

  // A full FIFO still takes a push when its head leaves in the same cycle.
  assign pop_s   = pop_i & ~empty_o;
  assign push_s  = push_i & (~full_o | pop_s);
  assign full_o  = (cnt_q == FULL_CNT);
  assign empty_o = (cnt_q == '0);
  assign data_o  = mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push_s) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      cnt_q <= cnt_q + {{AW{1'b0}}, push_s} - {{AW{1'b0}}, pop_s};
    end
  end
endmodule

module c157x_fser_port #(
  parameter int DATA_W  = 8,
  parameter int DEPTH   = 4,
  parameter int DIV     = 4,
  parameter int TIMEOUT = 64
) (
  input logic              clk,
  input logic              reset,
  c157x_fser_port_if.slave bus
);
  localparam int BW = $clog2(DATA_W + 1);
  localparam int DW = $clog2(DIV + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_W - 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, LOW = 2'd1, HIGH = 2'd2} tx_state_e;

  tx_state_e         state_q, state_d;
  logic [DW-1:0]     div_q, div_d;
  logic [BW-1:0]     tbit_q, tbit_d, rbit_q, rbit_d;
  logic [DATA_W-1:0] tx_sh_q, tx_sh_d, rx_sh_q, rx_sh_d, rx_word_s, tx_head_s;
  logic [TW-1:0]     to_q, to_d;
  logic              cnt_out_q, cnt_out_d, sp_out_q, sp_out_d;
  logic              cnt_meta_q, cnt_sync_q, cnt_prev_q, sp_meta_q, sp_sync_q, dir_q;
  logic              tx_done_q, rx_ovr_q, frame_err_q, irq_q;
  logic              tx_pop_s, tx_done_set_s, rx_push_s, frame_set_s;
  logic              tx_empty_s, rx_full_s, dir_chg_s, rise_s, busy_s;

  assign dir_chg_s    = bus.dir ^ dir_q;
  assign rise_s       = cnt_sync_q & ~cnt_prev_q;
  assign busy_s       = (state_q != IDLE) | (rbit_q != '0);
  assign bus.cnt_out  = cnt_out_q;
  assign bus.sp_out   = sp_out_q;
  assign bus.status   = {frame_err_q, rx_ovr_q, tx_done_q, busy_s};
  assign bus.irq      = irq_q;

  c157x_fser_fifo #(.W(DATA_W), .DEPTH(DEPTH)) u_tx_fifo (
    .clk(clk), .reset(reset), .push_i(bus.tx_wr), .data_i(bus.tx_data),
    .pop_i(tx_pop_s), .data_o(tx_head_s), .full_o(bus.tx_full), .empty_o(tx_empty_s)
  );

  c157x_fser_fifo #(.W(DATA_W), .DEPTH(DEPTH)) u_rx_fifo (
    .clk(clk), .reset(reset), .push_i(rx_push_s), .data_i(rx_word_s),
    .pop_i(bus.rx_rd), .data_o(bus.rx_data), .full_o(rx_full_s), .empty_o(bus.rx_empty)
  );

  // Transmit sequencing; a direction change overrides everything, ce or not.
  always_comb begin
    state_d       = state_q;
    div_d         = div_q;
    tbit_d        = tbit_q;
    tx_sh_d       = tx_sh_q;
    cnt_out_d     = cnt_out_q;
    sp_out_d      = sp_out_q;
    tx_pop_s      = 1'b0;
    tx_done_set_s = 1'b0;
    if (dir_chg_s) begin
      state_d   = IDLE;
      div_d     = '0;
      tbit_d    = '0;
      cnt_out_d = 1'b1;
      sp_out_d  = 1'b1;
    end else if (bus.ce) begin
      case (state_q)
        IDLE: begin
          cnt_out_d = 1'b1;
          sp_out_d  = 1'b1;
          if (bus.dir && !tx_empty_s) begin
            tx_pop_s  = 1'b1;
            tx_sh_d   = {tx_head_s[DATA_W-2:0], 1'b0};
            sp_out_d  = tx_head_s[DATA_W-1];
            cnt_out_d = 1'b0;
            tbit_d    = '0;
            div_d     = '0;
            state_d   = LOW;
          end else begin
            state_d = IDLE;
          end
        end
        LOW: begin
          if (div_q == DIV_LAST) begin
            div_d     = '0;
            cnt_out_d = 1'b1;
            state_d   = HIGH;
          end else begin
            div_d = div_q + DW'(1);
          end
        end
        HIGH: begin
          if (div_q == DIV_LAST) begin
            div_d = '0;
            if (tbit_q == BIT_LAST) begin
              tbit_d        = '0;
              sp_out_d      = 1'b1;
              tx_done_set_s = 1'b1;
              state_d       = IDLE;
            end else begin
              tbit_d    = tbit_q + BW'(1);
              cnt_out_d = 1'b0;
              sp_out_d  = tx_sh_q[DATA_W-1];
              tx_sh_d   = {tx_sh_q[DATA_W-2:0], 1'b0};
              state_d   = LOW;
            end
          end else begin
            div_d = div_q + DW'(1);
          end
        end
        default: begin
          state_d   = IDLE;
          cnt_out_d = 1'b1;
          sp_out_d  = 1'b1;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // Receive shifting on synchronized bus-clock rises, with partial-word timeout.
  always_comb begin
    rbit_d      = rbit_q;
    rx_sh_d     = rx_sh_q;
    to_d        = to_q;
    rx_push_s   = 1'b0;
    frame_set_s = 1'b0;
    rx_word_s   = {rx_sh_q[DATA_W-2:0], sp_sync_q};
    if (dir_chg_s || bus.dir) begin
      rbit_d = '0;
      to_d   = '0;
    end else if (rise_s) begin
      to_d    = '0;
      rx_sh_d = rx_word_s;
      if (rbit_q == BIT_LAST) begin
        rbit_d    = '0;
        rx_push_s = 1'b1;
      end else begin
        rbit_d = rbit_q + BW'(1);
      end
    end else if (bus.ce && (rbit_q != '0)) begin
      if (to_q == TO_LAST) begin
        rbit_d      = '0;
        to_d        = '0;
        frame_set_s = 1'b1;
      end else begin
        to_d = to_q + TW'(1);
      end
    end else begin
      to_d = to_q;
    end
  end

  // State, synchronizers and sticky status; a set beats a same-cycle clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_meta_q  <= 1'b1;
      cnt_sync_q  <= 1'b1;
      cnt_prev_q  <= 1'b1;
      sp_meta_q   <= 1'b1;
      sp_sync_q   <= 1'b1;
      dir_q       <= bus.dir;
      state_q     <= IDLE;
      div_q       <= '0;
      tbit_q      <= '0;
      tx_sh_q     <= '0;
      cnt_out_q   <= 1'b1;
      sp_out_q    <= 1'b1;
      rbit_q      <= '0;
      rx_sh_q     <= '0;
      to_q        <= '0;
      tx_done_q   <= 1'b0;
      rx_ovr_q    <= 1'b0;
      frame_err_q <= 1'b0;
      irq_q       <= 1'b0;
    end else begin
      cnt_meta_q  <= bus.cnt_in;
      cnt_sync_q  <= cnt_meta_q;
      cnt_prev_q  <= cnt_sync_q;
      sp_meta_q   <= bus.sp_in;
      sp_sync_q   <= sp_meta_q;
      dir_q       <= bus.dir;
      state_q     <= state_d;
      div_q       <= div_d;
      tbit_q      <= tbit_d;
      tx_sh_q     <= tx_sh_d;
      cnt_out_q   <= cnt_out_d;
      sp_out_q    <= sp_out_d;
      rbit_q      <= rbit_d;
      rx_sh_q     <= rx_sh_d;
      to_q        <= to_d;
      tx_done_q   <= (tx_done_q & ~bus.clr[1]) | tx_done_set_s;
      rx_ovr_q    <= (rx_ovr_q & ~bus.clr[2]) | (rx_push_s & rx_full_s & ~bus.rx_rd);
      frame_err_q <= (frame_err_q & ~bus.clr[3]) | frame_set_s;
      irq_q       <= ~bus.rx_empty | tx_done_q | rx_ovr_q | frame_err_q;
    end
  end
endmodule

// File: tb/tb_c157x_fser_port.sv
// Scoreboard bench for c157x_fser_port: word queues checked by TX/RX monitors,
// plus directed timing, overflow, timeout, abort and reset checks.
module tb_c157x_fser_port;
  localparam int DW = 8, DEPTH = 4, DIV = 2, TIMEOUT = 64;
  localparam int WORD_TICKS = 2 * DIV * DW;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  c157x_fser_port_if #(.DATA_W(DW)) bus ();
  c157x_fser_port #(.DATA_W(DW), .DEPTH(DEPTH), .DIV(DIV), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  int n_checks = 0;
  int n_pass = 0;
  int cyc = 0;
  logic [DW-1:0] tx_exp_q[$];
  logic [DW-1:0] rx_exp_q[$];
  int fall_q[$];
  bit ce_rand = 1'b0;
  logic ce_fixed = 1'b1;
  logic ce_rnd = 1'b1;
  bit rx_mon_en = 1'b0;

  assign bus.ce = ce_rand ? ce_rnd : ce_fixed;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    forever begin
      @(posedge clk);
      #1;
      ce_rnd = ($urandom_range(3) != 0);
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // TX monitor: rebuild MSB-first words from sp_out at each cnt_out rise.
  initial begin
    logic prev_c;
    logic [DW-1:0] acc;
    int nb;
    prev_c = 1'b1;
    acc = '0;
    nb = 0;
    forever begin
      @(negedge clk);
      if (reset || !bus.dir) begin
        nb = 0;
      end else begin
        if (prev_c && !bus.cnt_out) fall_q.push_back(cyc);
        if (!prev_c && bus.cnt_out) begin
          acc = {acc[DW-2:0], bus.sp_out};
          nb++;
          if (nb == DW) begin
            nb = 0;
            if (tx_exp_q.size() == 0) begin
              n_checks++;
              $display("FAIL tx_word: got unexpected 0x%0h, expected none", acc);
            end else begin
              chk("tx_word", int'(acc), int'(tx_exp_q.pop_front()));
            end
          end
        end
      end
      prev_c = bus.cnt_out;
    end
  end

  // RX monitor: randomly pops the FIFO head and compares it with the model.
  initial begin
    bus.rx_rd = 1'b0;
    forever begin
      @(negedge clk);
      bus.rx_rd = 1'b0;
      if (rx_mon_en && !reset && !bus.rx_empty && ($urandom_range(1) == 1)) begin
        if (rx_exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL rx_word: got unexpected 0x%0h, expected none", bus.rx_data);
        end else begin
          chk("rx_word", int'(bus.rx_data), int'(rx_exp_q.pop_front()));
        end
        bus.rx_rd = 1'b1;
      end
    end
  end

  task automatic push_tx(input logic [DW-1:0] d);
    int n = 0;
    while (bus.tx_full && n < 2000) begin
      step(1);
      n++;
    end
    if (n >= 2000) chk("tx_full_wait_budget", n, 0);
    bus.tx_data = d;
    bus.tx_wr = 1'b1;
    tx_exp_q.push_back(d);
    step(1);
    bus.tx_wr = 1'b0;
  endtask

  task automatic rx_bit(input logic b);
    bus.sp_in = b;
    bus.cnt_in = 1'b0;
    step(3);
    bus.cnt_in = 1'b1;
    step(3);
  endtask

  task automatic rx_word(input logic [DW-1:0] w);
    for (int i = DW - 1; i >= 0; i--) rx_bit(w[i]);
  endtask

  task automatic wait_drain(input string name, input bit is_tx, input int budget);
    int n = 0;
    while (((is_tx ? tx_exp_q.size() : rx_exp_q.size()) != 0) && n < budget) begin
      step(1);
      n++;
    end
    chk(name, is_tx ? tx_exp_q.size() : rx_exp_q.size(), 0);
  endtask

  task automatic clear_status(input logic [3:0] m);
    bus.clr = m;
    step(1);
    bus.clr = 4'b0000;
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_cnt_out"}, int'(bus.cnt_out), 1);
    chk({tag, "_sp_out"}, int'(bus.sp_out), 1);
    chk({tag, "_status"}, int'(bus.status), 0);
    chk({tag, "_irq"}, int'(bus.irq), 0);
    chk({tag, "_tx_full"}, int'(bus.tx_full), 0);
    chk({tag, "_rx_empty"}, int'(bus.rx_empty), 1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [DW-1:0] w;
    int n;
    bit saw_low;
    bus.dir = 1'b0;
    bus.tx_data = '0;
    bus.tx_wr = 1'b0;
    bus.sp_in = 1'b1;
    bus.cnt_in = 1'b1;
    bus.clr = 4'b0000;
    reset = 1'b1;
    step(3);
    check_reset_values("reset");
    reset = 1'b0;
    step(2);

    // Single word 0xA5: latency, bit period and irq one cycle after tx_done.
    bus.dir = 1'b1;
    step(2);
    fall_q.delete();
    push_tx(8'hA5);
    n = 0;
    while (!bus.status[1] && n < 200) begin
      step(1);
      n++;
    end
    chk("tx_done_latency", n, WORD_TICKS + 1);
    chk("irq_lags_tx_done", int'(bus.irq), 0);
    step(1);
    chk("irq_after_tx_done", int'(bus.irq), 1);
    chk("idle_cnt_out", int'(bus.cnt_out), 1);
    chk("idle_sp_out", int'(bus.sp_out), 1);
    chk("a5_pulse_count", fall_q.size(), DW);
    if (fall_q.size() >= DW) begin
      chk("a5_bit_period", fall_q[1] - fall_q[0], 2 * DIV);
      chk("a5_word_span", fall_q[DW-1] - fall_q[0], 2 * DIV * (DW - 1));
    end
    clear_status(4'b0010);
    chk("tx_done_cleared", int'(bus.status[1]), 0);

    // Back-to-back words: one idle tick between consecutive words.
    fall_q.delete();
    for (int i = 0; i < 3; i++) push_tx(8'($urandom));
    wait_drain("b2b_drain", 1'b1, 600);
    chk("b2b_pulse_count", fall_q.size(), 3 * DW);
    if (fall_q.size() >= 3 * DW) begin
      chk("b2b_gap_1", fall_q[DW] - fall_q[0], WORD_TICKS + 1);
      chk("b2b_gap_2", fall_q[2*DW] - fall_q[DW], WORD_TICKS + 1);
    end
    step(6);

    // Full TX FIFO: ignored write, then push and pop in the same cycle.
    ce_fixed = 1'b0;
    for (int i = 0; i < DEPTH; i++) push_tx(8'($urandom));
    chk("tx_full_at_depth", int'(bus.tx_full), 1);
    bus.tx_data = 8'hEE;
    bus.tx_wr = 1'b1;
    step(1);
    bus.tx_wr = 1'b0;
    chk("tx_full_after_ignored_wr", int'(bus.tx_full), 1);
    w = 8'($urandom);
    bus.tx_data = w;
    bus.tx_wr = 1'b1;
    ce_fixed = 1'b1;
    tx_exp_q.push_back(w);
    step(1);
    bus.tx_wr = 1'b0;
    chk("tx_full_push_pop", int'(bus.tx_full), 1);
    chk("busy_during_tx", int'(bus.status[0]), 1);
    wait_drain("full_corner_drain", 1'b1, 1500);
    step(6);
    clear_status(4'b0010);

    // Direction abort mid-word with two words queued.
    push_tx(8'($urandom));
    push_tx(8'($urandom));
    step(12);
    bus.dir = 1'b0;
    void'(tx_exp_q.pop_front());
    step(1);
    chk("abort_cnt_out", int'(bus.cnt_out), 1);
    chk("abort_sp_out", int'(bus.sp_out), 1);
    chk("abort_busy", int'(bus.status[0]), 0);
    step(40);
    chk("abort_no_tx_done", int'(bus.status[1]), 0);
    push_tx(8'($urandom));
    push_tx(8'($urandom));
    chk("abort_fifo_three", int'(bus.tx_full), 0);
    push_tx(8'($urandom));
    chk("abort_fifo_four", int'(bus.tx_full), 1);
    bus.dir = 1'b1;
    wait_drain("abort_resume_drain", 1'b1, 1500);
    step(6);
    bus.dir = 1'b0;
    step(3);
    clear_status(4'b0010);

    // Receive overflow: five words into a four-entry FIFO with no reads.
    rx_mon_en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      w = 8'((i + 1) * 8'h11);
      if (i < DEPTH) rx_exp_q.push_back(w);
      rx_word(w);
    end
    step(4);
    chk("ovr_rx_empty", int'(bus.rx_empty), 0);
    chk("ovr_head", int'(bus.rx_data), 8'h11);
    chk("ovr_flag", int'(bus.status[2]), 1);
    chk("ovr_irq", int'(bus.irq), 1);
    chk("ovr_busy", int'(bus.status[0]), 0);
    rx_mon_en = 1'b1;
    wait_drain("ovr_drain", 1'b0, 200);
    step(2);
    chk("ovr_empty_after_drain", int'(bus.rx_empty), 1);
    clear_status(4'b0100);
    chk("ovr_cleared", int'(bus.status[2]), 0);

    // Timeout on a 3-bit partial word, then a clean word.
    rx_bit(1'b1);
    rx_bit(1'b0);
    rx_bit(1'b1);
    chk("partial_busy", int'(bus.status[0]), 1);
    step(40);
    chk("no_early_timeout", int'(bus.status[3]), 0);
    step(30);
    chk("frame_err_set", int'(bus.status[3]), 1);
    chk("timeout_busy_clear", int'(bus.status[0]), 0);
    clear_status(4'b1000);
    rx_exp_q.push_back(8'h3C);
    rx_word(8'h3C);
    wait_drain("timeout_next_word", 1'b0, 200);
    chk("no_frame_err_after_word", int'(bus.status[3]), 0);

    // Randomized receive and transmit with a random clock enable.
    ce_rand = 1'b1;
    for (int i = 0; i < 6; i++) begin
      w = 8'($urandom);
      rx_exp_q.push_back(w);
      rx_word(w);
    end
    wait_drain("rand_rx_drain", 1'b0, 300);
    rx_mon_en = 1'b0;
    bus.dir = 1'b1;
    step(2);
    for (int i = 0; i < 6; i++) begin
      push_tx(8'($urandom));
      step($urandom_range(4));
    end
    wait_drain("rand_tx_drain", 1'b1, 4000);
    ce_rand = 1'b0;
    step(8);

    // Reset while the bus clock is high, with ce held low.
    push_tx(8'($urandom));
    push_tx(8'($urandom));
    saw_low = 1'b0;
    n = 0;
    while (n < 200) begin
      step(1);
      n++;
      if (!bus.cnt_out) saw_low = 1'b1;
      else if (saw_low) break;
    end
    chk("prereset_busy", int'(bus.status[0]), 1);
    chk("prereset_irq", int'(bus.irq), 1);
    ce_fixed = 1'b0;
    reset = 1'b1;
    tx_exp_q.delete();
    step(1);
    check_reset_values("midword_reset");
    reset = 1'b0;
    ce_fixed = 1'b1;
    step(4);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
